// File: rtl/fifo_demux_pkg.sv
// Shared definitions for the packet demux and its transmit-side counterpart.
// Both ends must decode the header count code the same way.
package fifo_demux_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    HDR,
    PAYLOAD
  } state_t;

  // Maps a header count code to the number of payload words that follow it.
  function automatic logic [CNT_W-1:0] cnt_decode(input logic [31:0] code);
    case (code)
      32'd0:   return 4'd0;
      32'd1:   return 4'd1;
      32'd2:   return 4'd2;
      32'd3:   return 4'd4;
      32'd4:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_demux_rx_skid2.sv
// Two-entry in-order holding buffer between the upstream FIFO read port
// and the packet steering logic. Entry 0 is always the head.
module fifo_skid2 #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic [1:0]    count_q;

  always_ff @(posedge clk) begin
    // NOTE: only two entries, so storage is reset too; this keeps the head data at 0 after reset.
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let mem[0] take the old mem[1] while mem[1] is refilled.
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) mem[0] <= push_data;
          else                 mem[1] <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          mem[0]  <= mem[1];
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            mem[0] <= push_data;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = mem[0];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/fifo_demux_rx.sv
// Pops header+payload packets from one upstream FIFO and steers each whole
// packet, in order, to FIFO1 or FIFO2 according to the header select bits.
module fifo_demux_rx
  import fifo_demux_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned SELMASK  = 1,
  parameter int unsigned CNTSHIFT = 1,
  parameter int unsigned CNTMASK  = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          empty_i,
  output logic          rd_en_o,
  output logic          f1_wr_en_o,
  output logic [DW-1:0] f1_wr_data_o,
  input  logic          f1_full_i,
  output logic          f2_wr_en_o,
  output logic [DW-1:0] f2_wr_data_o,
  input  logic          f2_full_i,
  output logic          pkt_done_o,
  output logic          busy_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dest1_q, dest1_d;
  logic             inflight_q;

  logic [DW-1:0]    head;
  logic             head_valid;
  logic [1:0]       skid_cnt;
  logic [1:0]       level;

  logic [DW-1:0]    code_word;
  logic [CNT_W-1:0] hdr_cnt;
  logic             hdr_sel1;
  logic             cur_dest1;
  logic             dest_full;
  logic             wr;

  fifo_skid2 #(.DW(DW)) u_skid (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (inflight_q),
    .push_data  (rd_data_i),
    .pop        (wr),
    .head       (head),
    .head_valid (head_valid),
    .count      (skid_cnt)
  );

  assign code_word = (head >> CNTSHIFT) & DW'(CNTMASK);
  assign hdr_cnt   = cnt_decode(32'(code_word));
  assign hdr_sel1  = |(head & DW'(SELMASK));

  // In HDR the head itself picks the destination; in PAYLOAD the latched one is used.
  assign cur_dest1 = (state_q == HDR) ? hdr_sel1 : dest1_q;
  assign dest_full = cur_dest1 ? f1_full_i : f2_full_i;
  assign wr        = head_valid && !dest_full && !rst_i;

  assign f1_wr_en_o   = wr && cur_dest1;
  assign f2_wr_en_o   = wr && !cur_dest1;
  assign f1_wr_data_o = head;
  assign f2_wr_data_o = head;

  // Occupancy next cycle once this cycle's drain and the returning read are applied.
  assign level   = skid_cnt - {1'b0, wr} + {1'b0, inflight_q};
  assign rd_en_o = !rst_i && !empty_i && (level < 2'd2);

  assign busy_o = !rst_i && ((state_q == PAYLOAD) || head_valid || inflight_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HDR;
      rem_q      <= '0;
      dest1_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dest1_q    <= dest1_d;
      inflight_q <= rd_en_o;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    rem_d      = rem_q;
    dest1_d    = dest1_q;
    pkt_done_o = 1'b0;
    if (wr) begin
      case (state_q)
        HDR: begin
          rem_d = hdr_cnt;
          if (hdr_cnt == '0) begin
            pkt_done_o = 1'b1;
          end else begin
            dest1_d = hdr_sel1;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          rem_d = rem_q - 1'b1;
          if (rem_q == 4'd1) begin
            pkt_done_o = 1'b1;
            state_d    = HDR;
          end
        end
        default: state_d = HDR;
      endcase
    end
  end

endmodule
